// File: rtl/result_collector_if.sv
// -----------------------------------------------------------------------------
// | Module   : result_collector_if                                             |
// | Brief    : Sample-side and row-drain signal bundle for result_collector.   |
// | Revision : 1.0                                                             |
// -----------------------------------------------------------------------------
`default_nettype none

interface result_collector_if #(
   parameter int MATRIX_SIZE = 2,
   parameter int DATA_SIZE   = 32
);
   logic                                       start;
   logic                                       sample_en;
   logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]      result_in;
   logic                                       output_ready;
   logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]      row_out;
   logic                                       row_valid;
   logic                                       row_last;
   logic                                       row_ready;
   logic                                       done;
   logic                                       overrun;

   modport master (
      output start, sample_en, result_in, row_ready,
      input  output_ready, row_out, row_valid, row_last, done, overrun
   );

   modport slave (
      input  start, sample_en, result_in, row_ready,
      output output_ready, row_out, row_valid, row_last, done, overrun
   );
endinterface

`default_nettype wire

// File: rtl/result_collector.sv
// -----------------------------------------------------------------------------
// | Module   : result_collector                                                |
// | Brief    : Deskews skewed systolic column outputs into rows, drains rows.  |
// | Revision : 1.0                                                             |
// -----------------------------------------------------------------------------
`default_nettype none

module result_collector #(
   parameter int MATRIX_SIZE = 2,
   parameter int DATA_SIZE   = 32,
   parameter int LATENCY     = 2
) (
   input  wire logic          clk,
   input  wire logic          reset,
   result_collector_if.slave  bus
);
   localparam int S_END = LATENCY + 2*MATRIX_SIZE - 2;
   localparam int CW    = $clog2(S_END + 2);
   localparam int PW    = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
   localparam logic [CW-1:0] S_LAST   = CW'(S_END);
   localparam logic [PW-1:0] PTR_LAST = PW'(MATRIX_SIZE - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   typedef logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   s_q, s_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic            done_q, done_d;
   logic            overrun_q, overrun_d;
   logic            output_ready_q;
   logic            row_valid_q;
   logic            row_last_q;
   row_t            row_out_q;
   row_t            rows_q [MATRIX_SIZE];
   row_t            rows_d [MATRIX_SIZE];
   logic            capture;

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      ptr_d     = ptr_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      rows_d    = rows_q;
      capture   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_COLLECT;
               capture = bus.sample_en;
            end
         end
         ST_COLLECT: begin
            capture = bus.sample_en;
         end
         ST_DRAIN: begin
            if (bus.sample_en) begin
               overrun_d = 1'b1;
            end
            if (row_valid_q && bus.row_ready) begin
               if (ptr_q == PTR_LAST) begin
                  state_d = ST_IDLE;
                  ptr_d   = '0;
                  s_d     = '0;
                  done_d  = 1'b1;
               end else begin
                  ptr_d = ptr_q + PW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Element (r,c) emerges on column c at sample index LATENCY + r + c.
      if (capture) begin
         for (int r = 0; r < MATRIX_SIZE; r++) begin
            for (int c = 0; c < MATRIX_SIZE; c++) begin
               if (s_q == CW'(LATENCY + r + c)) begin
                  rows_d[r][c] = bus.result_in[c];
               end
            end
         end
         s_d = s_q + CW'(1);
         if (s_q == S_LAST) begin
            state_d = ST_DRAIN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         s_q            <= '0;
         ptr_q          <= '0;
         done_q         <= 1'b0;
         overrun_q      <= 1'b0;
         output_ready_q <= 1'b1;
         row_valid_q    <= 1'b0;
         row_last_q     <= 1'b0;
         row_out_q      <= '0;
      end else begin
         state_q        <= state_d;
         s_q            <= s_d;
         ptr_q          <= ptr_d;
         done_q         <= done_d;
         overrun_q      <= overrun_d;
         output_ready_q <= (state_d != ST_DRAIN);
         row_valid_q    <= (state_d == ST_DRAIN);
         row_last_q     <= (state_d == ST_DRAIN) && (ptr_d == PTR_LAST);
         row_out_q      <= (state_d == ST_DRAIN) ? rows_d[ptr_d] : '0;
      end
   end

   // The buffer is deliberately left out of reset.
   always_ff @(posedge clk) begin
      rows_q <= rows_d;
   end

   assign bus.output_ready = output_ready_q;
   assign bus.row_out      = row_out_q;
   assign bus.row_valid    = row_valid_q;
   assign bus.row_last     = row_last_q;
   assign bus.done         = done_q;
   assign bus.overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_result_collector.sv
// -----------------------------------------------------------------------------
// | Module   : tb_result_collector                                             |
// | Brief    : Directed self-checking bench for result_collector (N=2 and N=4).|
// | Revision : 1.0                                                             |
// -----------------------------------------------------------------------------
`default_nettype none

module tb_result_collector;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   result_collector_if #(.MATRIX_SIZE(2), .DATA_SIZE(32)) a2 ();
   result_collector_if #(.MATRIX_SIZE(4), .DATA_SIZE(8))  a4 ();

   result_collector #(.MATRIX_SIZE(2), .DATA_SIZE(32), .LATENCY(2)) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (a2.slave)
   );

   result_collector #(.MATRIX_SIZE(4), .DATA_SIZE(8), .LATENCY(4)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (a4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One N=2 sample cycle: column values plus optional start.
   task automatic samp2(input logic [31:0] c0, input logic [31:0] c1, input logic st);
      a2.start        = st;
      a2.sample_en    = 1'b1;
      a2.result_in[0] = c0;
      a2.result_in[1] = c1;
      tick();
      a2.start     = 1'b0;
      a2.sample_en = 1'b0;
   endtask

   logic [31:0] exp4 [4];
   int          r4;

   initial begin
      checks   = 0;
      failures = 0;
      exp4[0] = 32'h03020100;
      exp4[1] = 32'h13121110;
      exp4[2] = 32'h23222120;
      exp4[3] = 32'h33323130;

      reset        = 1'b1;
      a2.start     = 1'b0;
      a2.sample_en = 1'b0;
      a2.result_in = '0;
      a2.row_ready = 1'b0;
      a4.start     = 1'b0;
      a4.sample_en = 1'b0;
      a4.result_in = '0;
      a4.row_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk("rst_output_ready", a2.output_ready, 1);
      chk("rst_row_valid",    a2.row_valid,    0);
      chk("rst_row_last",     a2.row_last,     0);
      chk("rst_done",         a2.done,         0);
      chk("rst_overrun",      a2.overrun,      0);
      chk("rst_row_out",      a2.row_out,      64'h0);
      chk("rst4_output_ready", a4.output_ready, 1);

      // Basic run
      samp2(0, 0, 1);
      samp2(0, 0, 0);
      samp2(11, 99, 0);
      samp2(21, 12, 0);
      chk("basic_pre_ready", a2.output_ready, 1);
      chk("basic_pre_valid", a2.row_valid,    0);
      samp2(77, 22, 0);
      chk("basic_ready_low", a2.output_ready, 0);
      chk("basic_row0_valid", a2.row_valid,   1);
      chk("basic_row0",      a2.row_out,      {32'd12, 32'd11});
      chk("basic_row0_last", a2.row_last,     0);
      a2.row_ready = 1'b1;
      tick();
      chk("basic_row1",      a2.row_out,      {32'd22, 32'd21});
      chk("basic_row1_last", a2.row_last,     1);
      tick();
      a2.row_ready = 1'b0;
      chk("basic_done",      a2.done,         1);
      chk("basic_ready_back", a2.output_ready, 1);
      chk("basic_valid_off", a2.row_valid,    0);
      tick();
      chk("basic_done_pulse", a2.done,        0);

      // Sample gaps followed by backpressure on row 0
      samp2(0, 0, 1);
      samp2(0, 0, 0);
      samp2(11, 99, 0);
      a2.result_in[0] = 32'd55;
      a2.result_in[1] = 32'd55;
      for (int g = 0; g < 3; g++) begin
         tick();
         chk("gap_collecting", a2.row_valid, 0);
      end
      samp2(21, 12, 0);
      samp2(77, 22, 0);
      for (int b = 0; b < 4; b++) begin
         tick();
         chk("bp_row0",   a2.row_out,   {32'd12, 32'd11});
         chk("bp_valid",  a2.row_valid, 1);
      end
      a2.row_ready = 1'b1;
      tick();
      chk("bp_row1", a2.row_out, {32'd22, 32'd21});
      tick();
      a2.row_ready = 1'b0;
      chk("bp_done", a2.done, 1);

      // Reset mid-collect, then ignored sample_en, then a fresh run
      samp2(0, 0, 1);
      samp2(0, 0, 0);
      samp2(11, 0, 0);
      reset           = 1'b1;
      a2.sample_en    = 1'b1;
      a2.result_in[0] = 32'd21;
      a2.result_in[1] = 32'd12;
      tick();
      reset        = 1'b0;
      a2.sample_en = 1'b0;
      chk("rstmid_ready", a2.output_ready, 1);
      chk("rstmid_valid", a2.row_valid,    0);
      samp2(5, 5, 0);
      chk("idle_se_ignored", a2.output_ready, 1);
      samp2(0, 0, 1);
      samp2(0, 0, 0);
      samp2(31, 0, 0);
      samp2(41, 32, 0);
      samp2(0, 42, 0);
      chk("fresh_row0", a2.row_out, {32'd32, 32'd31});
      a2.row_ready = 1'b1;
      tick();
      chk("fresh_row1", a2.row_out, {32'd42, 32'd41});
      tick();
      a2.row_ready = 1'b0;
      chk("fresh_done", a2.done, 1);

      // Busy start, overrun, and start accepted in the done cycle
      samp2(0, 0, 1);
      samp2(0, 0, 0);
      samp2(51, 0, 1);
      samp2(61, 52, 1);
      samp2(0, 62, 1);
      chk("ov_pre", a2.overrun, 0);
      a2.sample_en    = 1'b1;
      a2.start        = 1'b1;
      a2.result_in[0] = 32'd9;
      a2.result_in[1] = 32'd9;
      tick();
      a2.sample_en = 1'b0;
      a2.start     = 1'b0;
      chk("ov_set",    a2.overrun,      1);
      chk("ov_row0",   a2.row_out,      {32'd52, 32'd51});
      chk("ov_valid",  a2.row_valid,    1);
      chk("ov_ready",  a2.output_ready, 0);
      a2.row_ready = 1'b1;
      tick();
      chk("ov_row1",   a2.row_out,  {32'd62, 32'd61});
      chk("ov_last",   a2.row_last, 1);
      tick();
      a2.row_ready = 1'b0;
      chk("ov_done",   a2.done,    1);
      chk("ov_sticky", a2.overrun, 1);
      samp2(0, 0, 1);
      samp2(0, 0, 0);
      samp2(11, 0, 0);
      samp2(21, 12, 0);
      samp2(0, 22, 0);
      chk("donestart_valid", a2.row_valid, 1);
      chk("donestart_row0",  a2.row_out,   {32'd12, 32'd11});
      a2.row_ready = 1'b1;
      tick();
      tick();
      a2.row_ready = 1'b0;
      chk("donestart_done",  a2.done,    1);
      chk("ov_still_set",    a2.overrun, 1);

      // N=4, LATENCY=4: element (r,c) = 16r+c arrives at s = 4+r+c
      for (int s = 0; s <= 10; s++) begin
         a4.start     = (s == 0);
         a4.sample_en = 1'b1;
         for (int c = 0; c < 4; c++) begin
            r4 = s - 4 - c;
            a4.result_in[c] = (r4 >= 0 && r4 < 4) ? 8'(16*r4 + c) : 8'hEE;
         end
         if (s == 10) begin
            chk("n4_pre_valid", a4.row_valid,    0);
            chk("n4_pre_ready", a4.output_ready, 1);
         end
         tick();
      end
      a4.start     = 1'b0;
      a4.sample_en = 1'b0;
      chk("n4_ready_low", a4.output_ready, 0);
      a4.row_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         chk("n4_row",   a4.row_out,   exp4[r]);
         chk("n4_valid", a4.row_valid, 1);
         chk("n4_last",  a4.row_last,  (r == 3));
         tick();
      end
      a4.row_ready = 1'b0;
      chk("n4_done",  a4.done,         1);
      chk("n4_ready", a4.output_ready, 1);
      tick();
      chk("n4_done_clear", a4.done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/result_collector.md
# result_collector

Output-side receiver for the systolic array frame. Samples the skewed per-column `result_out` stream during a run, deskews it into an N×N row-aligned buffer, then drains one row per handshake to the downstream store. Drives the frame's `output_ready` so a new run cannot start until the previous result has been fully drained.

## Interface
- `MATRIX_SIZE`, default 2: N, the array dimension (rows and columns).
- `DATA_SIZE`, default 32: bit width of each result element.
- `LATENCY`, default 2: number of sample cycles from run start until column 0, row 0 is valid on `result_in[0]`.

Ports:
- `clk`  in  1: single clock for the whole block.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: run-start pulse, issued by the frame's enable condition.
- `sample_en`  in  1: high on every cycle in which the array advances.
- `result_in`  in  [DATA_SIZE-1:0] x MATRIX_SIZE: skewed column outputs from the array.
- `output_ready`  out  1: collector can accept a new run.
- `row_out`  out  [DATA_SIZE-1:0] x MATRIX_SIZE: deskewed row being offered downstream.
- `row_valid`  out  1: `row_out` is valid.
- `row_last`  out  1: the offered row is row N-1.
- `row_ready`  in  1: downstream accepts the row.
- `done`  out  1: one-cycle pulse after the last row is accepted.
- `overrun`  out  1: sticky flag, set if `sample_en` is high during DRAIN.

## Operation
- States: IDLE, COLLECT, DRAIN.
- Reset: state is IDLE; sample counter `s` = 0 and row pointer = 0. All outputs are 0 except `output_ready` = 1. The buffer is not cleared.
- **IDLE:** `output_ready` = 1.
  - If `start` = 1, go to COLLECT.
  - If `sample_en` is also high in that cycle, that cycle is sample `s` = 0 and is captured.
  - `sample_en` without `start` is ignored.
- **COLLECT:** `output_ready` = 1; `start` is ignored.
  - Capture rule, applied on each cycle with `sample_en` = 1: for every column c, if `s` − `LATENCY` − c lies in [0, N-1], then `buf[r][c]` <= `result_in[c]` with r = `s` − `LATENCY` − c.
  - `s` increments after each sample. `s` holds when `sample_en` = 0, so gaps are tolerated.
  - Final sample index is S_END = `LATENCY` + 2N − 2. The cycle that captures S_END transitions to DRAIN.
- **DRAIN:** `output_ready` = 0.
  - `row_out` = `buf[ptr]`, `row_valid` = 1, `row_last` = (ptr == N-1).
  - Outputs stay stable while `row_ready` = 0.
  - On `row_valid` && `row_ready`, ptr increments.
  - On the last-row handshake: go to IDLE, reset ptr and `s`, and pulse `done` in the next cycle.
  - `sample_en` = 1 in DRAIN sets `overrun`; the data is discarded. `overrun` clears only on `reset`.
- Counter width is $clog2(S_END+2) bits, which never wraps within a run.
- Reset asserted mid-COLLECT or mid-DRAIN aborts the run: state returns to IDLE and partial data is not drained.

## Timing
- All outputs are registered.
- `output_ready` falls in the cycle after the S_END capture edge. `row_valid` rises in that same cycle.
- Minimum drain is N cycles with `row_ready` held at 1.
- With continuous `sample_en`, collect-to-first-row latency is S_END+1 cycles from `start`.
- `done` is high exactly one cycle, coincident with the first IDLE cycle. `output_ready` = 1 in that same cycle.
- A `start` in the `done` cycle is accepted.

## Test plan
- **Basic run**, N=2, `LATENCY`=2, `sample_en` continuous from `start`.
  - Stimulus: s=2 {11,x}, s=3 {21,12}, s=4 {x,22}.
  - Required: rows {11,12} then {21,22}; `row_last` on the second row; `done` pulse; `output_ready` back to 1.
- **Sample gaps:** same data with `sample_en` low for 3 cycles between s=2 and s=3 -> identical rows; no capture during the gaps.
- **Backpressure:** `row_ready` low for 4 cycles on row 0 -> `row_out` = {11,12} held stable with `row_valid` = 1; no advance until `row_ready` = 1.
- **Reset mid-COLLECT:** `reset` at s=3 -> next cycle IDLE, `output_ready` = 1, `row_valid` = 0. A fresh run then produces correct rows.
- **Overrun and busy start:** `sample_en` during DRAIN -> `overrun` = 1 and stays high; buffer contents unchanged. `start` during COLLECT or DRAIN has no effect.
- **N=4, `LATENCY`=4:** element value = 16r+c -> four rows drained in order; S_END = 10; `done` follows the row-3 handshake.
